// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/control unit.
// Contents: stage index constants, forwarding select encoding and the
// shadow-pipeline slot payload.
package hazard_pkg;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned ST_F = 0;
  localparam int unsigned ST_D = 1;
  localparam int unsigned ST_E = 2;
  localparam int unsigned ST_M = 3;
  localparam int unsigned ST_W = 4;

  // Slot register field is sized for the largest supported register file.
  localparam int unsigned SLOT_REG_W = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/long_sb.sv
// Long-latency (TPU) write scoreboard: one busy bit per register plus the
// count of outstanding ops.
// Ports: clk/rst (sync, active-high), hold (pipeline frozen), set/set_reg
// (new long op issued), clr/clr_reg (long op completed), look_reg1..3 with
// busy1..3 lookups, full (outstanding == MAX_LONG), outstanding count.
module long_sb #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned MAX_LONG = 4,
  localparam int unsigned REG_W = $clog2(NUM_REGS),
  localparam int unsigned OUT_W = $clog2(MAX_LONG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             set,
  input  logic [REG_W-1:0] set_reg,
  input  logic             clr,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0] look_reg1,
  input  logic [REG_W-1:0] look_reg2,
  input  logic [REG_W-1:0] look_reg3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  output logic             full,
  output logic [OUT_W-1:0] outstanding
);

  logic [NUM_REGS-1:0] busy_q;
  logic [OUT_W-1:0]    out_q;
  logic                set_ok;
  logic                clr_ok;

  // A completion for a register that is not busy (e.g. after reset) is stale.
  assign clr_ok = clr && busy_q[clr_reg] && !hold;
  assign set_ok = set && !hold;

  assign busy1       = busy_q[look_reg1];
  assign busy2       = busy_q[look_reg2];
  assign busy3       = busy_q[look_reg3];
  assign full        = (out_q == OUT_W'(MAX_LONG));
  assign outstanding = out_q;

  // Set is applied after clear so a same-register reissue stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      out_q  <= '0;
    end else begin
      if (clr_ok) busy_q[clr_reg] <= 1'b0;
      if (set_ok) busy_q[set_reg] <= 1'b1;
      out_q <= out_q + OUT_W'(set_ok) - OUT_W'(clr_ok);
    end
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard and control-flow unit for the 5-stage core.
// Keeps a shadow E/M/W pipeline of destination registers, selects operand
// forwarding, tracks long-latency writes and drives per-stage stall/flush.
// Ports: clk_i/rst_i (sync, active-high); D-stage instruction info
// (d_*); long op completion (long_done_i/long_done_reg_i); branch and cache
// stall inputs; stall_o/flush_o per stage (0=F..4=W); fwd_sel1_o/fwd_sel2_o;
// stall_cnt_o counting hazard stall cycles.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned MAX_LONG = 4,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned REG_W = $clog2(NUM_REGS),
  localparam int unsigned OUT_W = $clog2(MAX_LONG + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_valid_i,
  input  logic [REG_W-1:0] d_op1_reg_i,
  input  logic [REG_W-1:0] d_op2_reg_i,
  input  logic             d_op1_used_i,
  input  logic             d_op2_used_i,
  input  logic [REG_W-1:0] d_dest_reg_i,
  input  logic             d_reg_we_i,
  input  logic             d_is_load_i,
  input  logic             d_is_long_i,
  input  logic             long_done_i,
  input  logic [REG_W-1:0] long_done_reg_i,
  input  logic             branch_taken_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic [1:0]       fwd_sel1_o,
  output logic [1:0]       fwd_sel2_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  slot_t slot_e, slot_m, slot_w;
  slot_t next_e;

  logic [1:0]       hit_e, hit_m, hit_w;
  logic [1:0]       src_used;
  fwd_sel_e         fwd_c [2];
  logic             raw_stall_c;
  logic             long_stall_c;
  logic             hazard_c;
  logic             issue_c;
  logic             long_set_c;
  logic             busy1, busy2, busy3, full;
  logic [OUT_W-1:0] outstanding;
  logic             unused_bits;

  function automatic logic raw_hit(slot_t sl, logic [REG_W-1:0] r, logic u);
    return u && (r != '0) && sl.valid && sl.we && (sl.rd == SLOT_REG_W'(r));
  endfunction

  assign src_used = {d_op2_used_i, d_op1_used_i};
  assign hit_e[0] = raw_hit(slot_e, d_op1_reg_i, d_op1_used_i);
  assign hit_e[1] = raw_hit(slot_e, d_op2_reg_i, d_op2_used_i);
  assign hit_m[0] = raw_hit(slot_m, d_op1_reg_i, d_op1_used_i);
  assign hit_m[1] = raw_hit(slot_m, d_op2_reg_i, d_op2_used_i);
  assign hit_w[0] = raw_hit(slot_w, d_op1_reg_i, d_op1_used_i);
  assign hit_w[1] = raw_hit(slot_w, d_op2_reg_i, d_op2_used_i);

  // Only a load sitting in E cannot be forwarded; the youngest producer wins.
  always_comb begin
    raw_stall_c = 1'b0;
    fwd_c[0]    = FWD_RF;
    fwd_c[1]    = FWD_RF;
    for (int s = 0; s < 2; s++) begin
      if (FWD_EN != 0) begin
        if (hit_e[s] && slot_e.is_load) raw_stall_c = d_valid_i;
        else if (hit_e[s])              fwd_c[s] = FWD_E;
        else if (hit_m[s])              fwd_c[s] = FWD_M;
        else if (hit_w[s])              fwd_c[s] = FWD_W;
      end else if (hit_e[s] || hit_m[s] || hit_w[s]) begin
        raw_stall_c = d_valid_i;
      end
    end
  end

  assign long_stall_c = d_valid_i &&
                        ((busy1 && src_used[0]) || (busy2 && src_used[1]) || busy3 ||
                         (d_is_long_i && full));

  // Priority: reset, freeze, branch redirect, hazard, fetch miss.
  always_comb begin
    stall_o    = '0;
    flush_o    = '0;
    fwd_sel1_o = FWD_RF;
    fwd_sel2_o = FWD_RF;
    hazard_c   = 1'b0;
    if (rst_i) begin
      flush_o = '1;
    end else begin
      fwd_sel1_o = fwd_c[0];
      fwd_sel2_o = fwd_c[1];
      if (dcache_stall_i) begin
        stall_o = '1;
      end else if (branch_taken_i) begin
        flush_o[ST_E] = 1'b1;
        flush_o[ST_D] = 1'b1;
        stall_o[ST_F] = icache_stall_i;
      end else if (raw_stall_c || long_stall_c) begin
        stall_o[ST_F] = 1'b1;
        stall_o[ST_D] = 1'b1;
        flush_o[ST_E] = 1'b1;
        hazard_c      = 1'b1;
      end else if (icache_stall_i) begin
        stall_o[ST_F] = 1'b1;
        flush_o[ST_D] = 1'b1;
      end
    end
  end

  assign issue_c    = d_valid_i && !rst_i && !dcache_stall_i && !branch_taken_i && !hazard_c;
  assign long_set_c = issue_c && d_is_long_i && d_reg_we_i && (d_dest_reg_i != '0);

  // Long results return through long_done_i, so E never advertises them.
  always_comb begin
    next_e = '0;
    if (issue_c) begin
      next_e.valid   = 1'b1;
      next_e.rd      = SLOT_REG_W'(d_dest_reg_i);
      next_e.we      = d_reg_we_i && !d_is_long_i;
      next_e.is_load = d_is_load_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_e <= '0;
      slot_m <= '0;
      slot_w <= '0;
    end else if (!dcache_stall_i) begin
      slot_w <= slot_m;
      slot_m <= slot_e;
      slot_e <= next_e;
    end
  end

  // Saturating hazard stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (hazard_c && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  // Completions are applied only on unfrozen cycles, like all other state.
  long_sb #(
    .NUM_REGS (NUM_REGS),
    .MAX_LONG (MAX_LONG)
  ) u_long_sb (
    .clk         (clk_i),
    .rst         (rst_i),
    .hold        (dcache_stall_i),
    .set         (long_set_c),
    .set_reg     (d_dest_reg_i),
    .clr         (long_done_i),
    .clr_reg     (long_done_reg_i),
    .look_reg1   (d_op1_reg_i),
    .look_reg2   (d_op2_reg_i),
    .look_reg3   (d_dest_reg_i),
    .busy1       (busy1),
    .busy2       (busy2),
    .busy3       (busy3),
    .full        (full),
    .outstanding (outstanding)
  );

  assign unused_bits = ^{slot_m.is_load, slot_w.is_load, outstanding};

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed bench for hazard_ctrl_sb (default parameters).
module tb_hazard_ctrl_sb;

  localparam int unsigned REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             d_valid;
  logic [REG_W-1:0] d_op1_reg, d_op2_reg, d_dest_reg;
  logic             d_op1_used, d_op2_used, d_reg_we, d_is_load, d_is_long;
  logic             long_done;
  logic [REG_W-1:0] long_done_reg;
  logic             branch_taken, icache_stall, dcache_stall;
  logic [4:0]       stall_o, flush_o;
  logic [1:0]       fwd_sel1_o, fwd_sel2_o;
  logic [31:0]      stall_cnt_o;

  typedef struct {
    string      tag;
    logic [4:0] st;
    logic [4:0] fl;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cnt_model = 0;

  always #5 clk = ~clk;

  hazard_ctrl_sb dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .d_valid_i       (d_valid),
    .d_op1_reg_i     (d_op1_reg),
    .d_op2_reg_i     (d_op2_reg),
    .d_op1_used_i    (d_op1_used),
    .d_op2_used_i    (d_op2_used),
    .d_dest_reg_i    (d_dest_reg),
    .d_reg_we_i      (d_reg_we),
    .d_is_load_i     (d_is_load),
    .d_is_long_i     (d_is_long),
    .long_done_i     (long_done),
    .long_done_reg_i (long_done_reg),
    .branch_taken_i  (branch_taken),
    .icache_stall_i  (icache_stall),
    .dcache_stall_i  (dcache_stall),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .fwd_sel1_o      (fwd_sel1_o),
    .fwd_sel2_o      (fwd_sel2_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_d(input logic v, input int o1, input logic u1, input int o2,
                       input logic u2, input int dest, input logic we,
                       input logic ld, input logic lng);
    d_valid    = v;
    d_op1_reg  = REG_W'(o1);
    d_op1_used = u1;
    d_op2_reg  = REG_W'(o2);
    d_op2_used = u2;
    d_dest_reg = REG_W'(dest);
    d_reg_we   = we;
    d_is_load  = ld;
    d_is_long  = lng;
  endtask

  task automatic clear_d();
    set_d(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation, compare at the falling edge, then pass the rising edge.
  task automatic cyc(input string tag, input logic [4:0] st, input logic [4:0] fl,
                     input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    exp_t got;
    e.tag = tag; e.st = st; e.fl = fl; e.f1 = f1; e.f2 = f2;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    check({got.tag, ".stall"}, 32'(stall_o),    32'(got.st));
    check({got.tag, ".flush"}, 32'(flush_o),    32'(got.fl));
    check({got.tag, ".fwd1"},  32'(fwd_sel1_o), 32'(got.f1));
    check({got.tag, ".fwd2"},  32'(fwd_sel2_o), 32'(got.f2));
    check({got.tag, ".cnt"},   stall_cnt_o,     32'(cnt_model));
    if (rst) cnt_model = 0;
    else if (got.st == 5'b00011 && got.fl == 5'b00100) cnt_model++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_d();
    long_done = 1'b0; long_done_reg = '0;
    branch_taken = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 5'b00000, 5'b11111, 2'd0, 2'd0);
    rst = 1'b0;

    // load-use then forward from M
    set_d(1, 2, 1, 0, 0, 5, 1, 1, 0);  cyc("ld",       5'b00000, 5'b00000, 0, 0);
    set_d(1, 5, 1, 1, 1, 6, 1, 0, 0);  cyc("lu_stall", 5'b00011, 5'b00100, 0, 0);
                                       cyc("lu_fwd",   5'b00000, 5'b00000, 2, 0);
    // ALU chain forwarding from E, M, W
    set_d(1, 1, 1, 2, 1, 3, 1, 0, 0);  cyc("add3",     5'b00000, 5'b00000, 0, 0);
    set_d(1, 3, 1, 3, 1, 4, 1, 0, 0);  cyc("sub_fwd",  5'b00000, 5'b00000, 1, 1);
    set_d(1, 6, 1, 3, 1, 8, 1, 0, 0);  cyc("fwd_mw",   5'b00000, 5'b00000, 3, 2);
    set_d(1, 8, 0, 4, 1, 9, 1, 0, 0);  cyc("unused",   5'b00000, 5'b00000, 0, 2);
    clear_d();
    for (int i = 0; i < 3; i++) cyc("drain", 5'b00000, 5'b00000, 0, 0);

    // long op: reader waits for completion, issues the next cycle
    set_d(1, 1, 1, 0, 0, 7, 1, 0, 1);  cyc("long7",     5'b00000, 5'b00000, 0, 0);
    set_d(1, 7, 1, 0, 0, 9, 1, 0, 0);  cyc("long_wait", 5'b00011, 5'b00100, 0, 0);
                                       cyc("long_wait", 5'b00011, 5'b00100, 0, 0);
    long_done = 1'b1; long_done_reg = 5'd7;
    cyc("long_done_cyc", 5'b00011, 5'b00100, 0, 0);
    long_done = 1'b0;
    cyc("long_rd_issue", 5'b00000, 5'b00000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      set_d(1, 0, 0, 0, 0, 10 + i, 1, 0, 1);
      cyc("long_fill", 5'b00000, 5'b00000, 0, 0);
    end
    set_d(1, 0, 0, 0, 0, 14, 1, 0, 1);   cyc("long_full",     5'b00011, 5'b00100, 0, 0);
    set_d(1, 0, 0, 0, 0, 11, 1, 0, 0);   cyc("waw",           5'b00011, 5'b00100, 0, 0);
    set_d(1, 0, 0, 12, 1, 15, 1, 0, 0);  cyc("long_busy_op2", 5'b00011, 5'b00100, 0, 0);
    clear_d();

    // freeze holds the shadow pipeline: load-use still seen afterwards
    set_d(1, 2, 1, 0, 0, 5, 1, 1, 0);  cyc("ld_b", 5'b00000, 5'b00000, 0, 0);
    set_d(1, 5, 1, 0, 0, 6, 1, 0, 0);
    dcache_stall = 1'b1;
    cyc("freeze", 5'b11111, 5'b00000, 0, 0);
    cyc("freeze", 5'b11111, 5'b00000, 0, 0);
    dcache_stall = 1'b0;
    cyc("lu_after_freeze", 5'b00011, 5'b00100, 0, 0);

    // branch overrides a load-use hazard
    set_d(1, 2, 1, 0, 0, 5, 1, 1, 0);  cyc("ld_c", 5'b00000, 5'b00000, 0, 0);
    set_d(1, 5, 1, 0, 0, 6, 1, 0, 0);
    branch_taken = 1'b1;
    cyc("br_lu", 5'b00000, 5'b00110, 0, 0);
    branch_taken = 1'b0;
    clear_d();
    cyc("br_after", 5'b00000, 5'b00000, 0, 0);

    // branch deferred by freeze, then fetch miss alone
    set_d(1, 1, 1, 0, 0, 20, 1, 0, 0);
    branch_taken = 1'b1; dcache_stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("frz_br", 5'b11111, 5'b00000, 0, 0);
    dcache_stall = 1'b0;
    cyc("br_unfrz", 5'b00000, 5'b00110, 0, 0);
    branch_taken = 1'b0; icache_stall = 1'b1;
    cyc("icache", 5'b00001, 5'b00010, 0, 0);
    icache_stall = 1'b0;
    clear_d();

    // retire two of four long ops, leaving r12/r13 outstanding
    long_done = 1'b1; long_done_reg = 5'd10; cyc("done10", 5'b00000, 5'b00000, 0, 0);
    long_done_reg = 5'd11;                   cyc("done11", 5'b00000, 5'b00000, 0, 0);
    long_done = 1'b0;
    set_d(1, 12, 1, 0, 0, 16, 1, 0, 0);  cyc("busy12", 5'b00011, 5'b00100, 0, 0);

    // reset discards outstanding long ops
    rst = 1'b1;
    cyc("reset2", 5'b00000, 5'b11111, 0, 0);
    rst = 1'b0;
    cyc("post_rst_rd12", 5'b00000, 5'b00000, 0, 0);
    clear_d();
    long_done = 1'b1; long_done_reg = 5'd12;
    cyc("late_done", 5'b00000, 5'b00000, 0, 0);
    long_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_d(1, 0, 0, 0, 0, 1 + i, 1, 0, 1);
      cyc("refill", 5'b00000, 5'b00000, 0, 0);
    end
    set_d(1, 0, 0, 0, 0, 5, 1, 0, 1);  cyc("refull", 5'b00011, 5'b00100, 0, 0);

    // register 0 never hazards
    set_d(1, 0, 0, 0, 0, 0, 1, 0, 0);  cyc("w_r0",  5'b00000, 5'b00000, 0, 0);
    set_d(1, 0, 1, 0, 1, 0, 1, 0, 0);  cyc("rd_r0", 5'b00000, 5'b00000, 0, 0);
    clear_d();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
